// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate-generation stage: upstream beat in,
// decoded immediate/target beat out.
interface imm_gen_pipe_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;

   // Environment side: feeds instructions, consumes results.
   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
   );

   // Stage side.
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: format classify, immediate extend and
// pc+imm target, registered behind a valid/ready port with optional skid entry.
module imm_gen_pipe #(
   parameter int unsigned XLEN = 32,
   parameter bit          SKID = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   imm_gen_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_J   = 3'd4,
      FMT_U   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      fmt_e            fmt;
      logic            illegal;
   } beat_t;

   // Bit 0 is "output register valid", bit 1 is "skid entry valid".
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_ONE   = 2'b01,
      OCC_FULL  = 2'b11
   } occ_e;

   logic [31:0] instr;
   beat_t       dec;
   beat_t       out_q;
   beat_t       skid_q;
   occ_e        occ_q;
   occ_e        occ_d;
   logic        in_ready;
   logic        accept;
   logic        drain;
   logic        load_out;
   logic        load_skid;
   logic        from_skid;

   assign instr = bus.in_instr;

   always_comb begin
      dec         = '0;
      dec.fmt     = FMT_ILL;
      dec.illegal = 1'b1;
      dec.pc      = bus.in_pc;
      case (instr[6:0])
         7'b0010011: begin
            dec.fmt     = FMT_I;
            dec.illegal = 1'b0;
            if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
               dec.imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            end else begin
               dec.imm = XLEN'($signed(instr[31:20]));
            end
         end
         7'b0000011, 7'b1100111, 7'b1110011: begin
            dec.fmt     = FMT_I;
            dec.illegal = 1'b0;
            dec.imm     = XLEN'($signed(instr[31:20]));
         end
         7'b0100011: begin
            dec.fmt     = FMT_S;
            dec.illegal = 1'b0;
            dec.imm     = XLEN'($signed({instr[31:25], instr[11:7]}));
         end
         7'b1100011: begin
            dec.fmt     = FMT_B;
            dec.illegal = 1'b0;
            dec.imm     = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         end
         7'b1101111: begin
            dec.fmt     = FMT_J;
            dec.illegal = 1'b0;
            dec.imm     = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt     = FMT_U;
            dec.illegal = 1'b0;
            dec.imm     = XLEN'($signed({instr[31:12], 12'b0}));
         end
         7'b0110011: begin
            dec.fmt     = FMT_R;
            dec.illegal = 1'b0;
         end
         default: ;
      endcase
      dec.target = bus.in_pc + dec.imm;
   end

   generate
      if (SKID) begin : g_skid
         assign in_ready = ~occ_q[1];
      end else begin : g_noskid
         assign in_ready = bus.out_ready | ~occ_q[0];
      end
   endgenerate

   assign accept = bus.in_valid & in_ready;
   assign drain  = occ_q[0] & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= OCC_EMPTY;
      end else begin
         occ_q <= occ_d;
      end
   end

   // Without SKID in_ready is low whenever ONE stalls, so FULL is never entered.
   always_comb begin
      occ_d     = occ_q;
      load_out  = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (accept) begin
                  load_out = 1'b1;
                  occ_d    = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (drain) begin
                  if (accept) begin
                     load_out = 1'b1;
                  end else begin
                     occ_d = OCC_EMPTY;
                  end
               end else if (accept) begin
                  load_skid = 1'b1;
                  occ_d     = OCC_FULL;
               end
            end
            OCC_FULL: begin
               if (drain) begin
                  load_out  = 1'b1;
                  from_skid = 1'b1;
                  occ_d     = OCC_ONE;
               end
            end
            default: occ_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out) begin
            out_q <= from_skid ? skid_q : dec;
         end
         if (load_skid) begin
            skid_q <= dec;
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = occ_q[0];
   assign bus.out_imm     = out_q.imm;
   assign bus.out_fmt     = out_q.fmt;
   assign bus.out_target  = out_q.target;
   assign bus.out_pc      = out_q.pc;
   assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32-bit skid, 64-bit skid and 32-bit
// no-skid instances driven in sequence from one initial block.
module tb_imm_gen_pipe;

   logic clk;
   logic rst_n;
   logic flush;
   int   n_pass;
   int   n_fail;
   int   n_total;

   imm_gen_pipe_if #(.XLEN(32)) a ();
   imm_gen_pipe_if #(.XLEN(64)) b ();
   imm_gen_pipe_if #(.XLEN(32)) c ();

   imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(a));
   imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b));
   imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) u0  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      a.in_valid = v;
      a.in_instr = ins;
      a.in_pc    = pc;
   endtask

   task automatic check_a(input string tag, input logic [2:0] fmt, input logic [31:0] imm,
                          input logic [31:0] tgt, input logic [31:0] pc);
      chk({tag, ".valid"}, a.out_valid, 1'b1);
      chk({tag, ".fmt"}, a.out_fmt, fmt);
      chk({tag, ".imm"}, a.out_imm, imm);
      chk({tag, ".target"}, a.out_target, tgt);
      chk({tag, ".pc"}, a.out_pc, pc);
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      rst_n = 1'b0; flush = 1'b0;
      a.in_valid = 1'b0; a.in_instr = '0; a.in_pc = '0; a.out_ready = 1'b1;
      b.in_valid = 1'b0; b.in_instr = '0; b.in_pc = '0; b.out_ready = 1'b1;
      c.in_valid = 1'b0; c.in_instr = '0; c.in_pc = '0; c.out_ready = 1'b1;

      #12;
      chk("rst.in_ready", a.in_ready, 1'b1);
      chk("rst.out_valid", a.out_valid, 1'b0);
      chk("rst.out_imm", a.out_imm, 32'h0);
      chk("rst.out_fmt", a.out_fmt, 3'd0);
      chk("rst.out_target", a.out_target, 32'h0);
      chk("rst.out_pc", a.out_pc, 32'h0);
      chk("rst.out_illegal", a.out_illegal, 1'b0);
      #10 rst_n = 1'b1;
      step();
      chk("post_rst.in_ready", a.in_ready, 1'b1);
      chk("post_rst.out_valid", a.out_valid, 1'b0);

      // Back-to-back beats with out_ready high: one result per cycle.
      drive_a(1'b1, 32'hFFF00093, 32'h100);
      step();
      check_a("addi", 3'd1, 32'hFFFFFFFF, 32'h000000FF, 32'h100);
      chk("addi.illegal", a.out_illegal, 1'b0);
      drive_a(1'b1, 32'h00000463, 32'h100);
      step();
      check_a("beq", 3'd3, 32'h8, 32'h108, 32'h100);
      chk("beq.in_ready", a.in_ready, 1'b1);
      drive_a(1'b1, 32'hFFDFF06F, 32'h200);
      step();
      check_a("jal", 3'd4, 32'hFFFFFFFC, 32'h1FC, 32'h200);
      drive_a(1'b1, 32'hFE112C23, 32'h300);
      step();
      check_a("sw", 3'd2, 32'hFFFFFFF8, 32'h2F8, 32'h300);
      drive_a(1'b1, 32'h12345017, 32'h10);
      step();
      check_a("auipc", 3'd5, 32'h12345000, 32'h12345010, 32'h10);
      drive_a(1'b1, 32'h002081B3, 32'h40);
      step();
      check_a("add", 3'd0, 32'h0, 32'h40, 32'h40);
      drive_a(1'b1, 32'h4030D093, 32'h0);
      step();
      check_a("srai", 3'd1, 32'h3, 32'h3, 32'h0);
      drive_a(1'b1, 32'hFFF00093, 32'hFFFFFFFF);
      step();
      check_a("wrap", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF);
      drive_a(1'b0, 32'h0, 32'h0);
      step();
      chk("drain.out_valid", a.out_valid, 1'b0);

      // Backpressure: A on output, B in skid, C held off.
      a.out_ready = 1'b0;
      drive_a(1'b1, 32'h00100093, 32'h1000);
      step();
      check_a("bp.A", 3'd1, 32'h1, 32'h1001, 32'h1000);
      chk("bp.A.in_ready", a.in_ready, 1'b1);
      drive_a(1'b1, 32'h00100093, 32'h2000);
      step();
      chk("bp.B.out_pc", a.out_pc, 32'h1000);
      chk("bp.B.in_ready", a.in_ready, 1'b0);
      drive_a(1'b1, 32'h00100093, 32'h3000);
      step();
      chk("bp.C.out_pc", a.out_pc, 32'h1000);
      chk("bp.C.in_ready", a.in_ready, 1'b0);
      a.out_ready = 1'b1;
      step();
      check_a("bp.outB", 3'd1, 32'h1, 32'h2001, 32'h2000);
      chk("bp.outB.in_ready", a.in_ready, 1'b1);
      step();
      check_a("bp.outC", 3'd1, 32'h1, 32'h3001, 32'h3000);
      drive_a(1'b0, 32'h0, 32'h0);
      step();
      chk("bp.empty", a.out_valid, 1'b0);

      // Flush with skid full and a beat presented.
      a.out_ready = 1'b0;
      drive_a(1'b1, 32'h00100093, 32'h4000);
      step();
      drive_a(1'b1, 32'h00100093, 32'h5000);
      step();
      chk("fl.full.in_ready", a.in_ready, 1'b0);
      drive_a(1'b1, 32'h00100093, 32'h6000);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl.out_valid", a.out_valid, 1'b0);
      chk("fl.in_ready", a.in_ready, 1'b1);
      drive_a(1'b0, 32'h0, 32'h0);
      a.out_ready = 1'b1;
      step();
      chk("fl.stays_empty", a.out_valid, 1'b0);

      // Flush with in_ready high: the presented beat must be dropped.
      drive_a(1'b1, 32'h00100093, 32'h7000);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive_a(1'b0, 32'h0, 32'h0);
      chk("fl2.out_valid", a.out_valid, 1'b0);
      step();
      chk("fl2.stays_empty", a.out_valid, 1'b0);

      // XLEN=64 instance.
      b.in_valid = 1'b1; b.in_instr = 32'h800000B7; b.in_pc = 64'h0;
      step();
      chk("x64.lui.fmt", b.out_fmt, 3'd5);
      chk("x64.lui.imm", b.out_imm, 64'hFFFFFFFF80000000);
      chk("x64.lui.target", b.out_target, 64'hFFFFFFFF80000000);
      b.in_instr = 32'h02809093; b.in_pc = 64'h1000;
      step();
      chk("x64.slli.fmt", b.out_fmt, 3'd1);
      chk("x64.slli.imm", b.out_imm, 64'h28);
      chk("x64.slli.target", b.out_target, 64'h1028);
      b.in_instr = 32'hFFDFF06F; b.in_pc = 64'h2;
      step();
      chk("x64.jal.imm", b.out_imm, 64'hFFFFFFFFFFFFFFFC);
      chk("x64.jal.target", b.out_target, 64'hFFFFFFFFFFFFFFFE);
      b.in_valid = 1'b0;
      step();
      chk("x64.empty", b.out_valid, 1'b0);

      // SKID=0 instance: in_ready follows out_ready combinationally.
      c.out_ready = 1'b0;
      c.in_valid = 1'b1; c.in_instr = 32'h00100093; c.in_pc = 32'h10;
      step();
      chk("ns.out_valid", c.out_valid, 1'b1);
      chk("ns.out_pc", c.out_pc, 32'h10);
      chk("ns.stall.in_ready", c.in_ready, 1'b0);
      c.in_pc = 32'h20;
      step();
      chk("ns.hold.out_pc", c.out_pc, 32'h10);
      c.out_ready = 1'b1;
      #1;
      chk("ns.comb.in_ready", c.in_ready, 1'b1);
      step();
      chk("ns.next.out_pc", c.out_pc, 32'h20);
      chk("ns.next.target", c.out_target, 32'h21);
      c.in_valid = 1'b0;
      step();
      chk("ns.empty", c.out_valid, 1'b0);

      // Illegal opcode, then async reset while beats are held.
      a.out_ready = 1'b0;
      drive_a(1'b1, 32'h0000007F, 32'h80);
      step();
      check_a("ill", 3'd7, 32'h0, 32'h80, 32'h80);
      chk("ill.illegal", a.out_illegal, 1'b1);
      drive_a(1'b1, 32'h00100093, 32'h90);
      step();
      chk("ill.skid.in_ready", a.in_ready, 1'b0);
      drive_a(1'b0, 32'h0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.out_valid", a.out_valid, 1'b0);
      chk("mrst.out_fmt", a.out_fmt, 3'd0);
      chk("mrst.out_illegal", a.out_illegal, 1'b0);
      chk("mrst.out_pc", a.out_pc, 32'h0);
      chk("mrst.out_target", a.out_target, 32'h0);
      chk("mrst.in_ready", a.in_ready, 1'b1);
      #3 rst_n = 1'b1;
      a.out_ready = 1'b1;
      step();
      step();
      chk("mrst.no_ghost", a.out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
